// File: rtl/i2c_target_responder_if.sv
// I2C target bus bundle: raw SCL/SDA lines, open-drain pull enable and fabric byte handshake.
`timescale 1ns/1ps
interface i2c_target_responder_if;
  logic       scl;
  logic       sda;
  logic       sda_pull_low;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_request;
  logic       busy;
  logic       rw;
  logic       general_call;

  modport master (
    output scl, sda, tx_data,
    input  sda_pull_low, rx_data, rx_valid, tx_request, busy, rw, general_call
  );

  modport slave (
    input  scl, sda, tx_data,
    output sda_pull_low, rx_data, rx_valid, tx_request, busy, rw, general_call
  );
endinterface

// File: rtl/i2c_target_responder.sv
// I2C target endpoint: oversampled SCL/SDA, START/STOP detection, 7-bit address match, byte RX/TX.
// Optional GENERAL_CALL_EN: also acknowledge the general-call write address 8'h00.
`timescale 1ns/1ps
module i2c_target_responder #(
  parameter logic [6:0]  ADDRESS     = 7'h48,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic                    clk,
  input logic                    rst_n,
  i2c_target_responder_if.slave  bus
);

`ifdef GENERAL_CALL_EN
  localparam bit GC_EN = 1'b1;
`else
  localparam bit GC_EN = 1'b0;
`endif

  localparam int unsigned CNT_W = 4;

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP
  } state_t;

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic                   scl_d, sda_d;
  logic                   scl_s, sda_s;
  logic                   scl_rise, scl_fall, start, stop;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] bit_cnt, bit_cnt_nxt;
  logic [7:0]       shift, shift_nxt;
  logic [7:0]       rx_data, rx_data_nxt;
  logic             pull_low, pull_low_nxt;
  logic             rx_valid, rx_valid_nxt;
  logic             tx_request, tx_request_nxt;
  logic             busy, busy_nxt;
  logic             rw, rw_nxt;
  logic             gcall, gcall_nxt;

  // Synchroniser chain plus one history flop; idle bus level is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], bus.scl};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], bus.sda};
      scl_d    <= scl_sync[SYNC_STAGES-1];
      sda_d    <= sda_sync[SYNC_STAGES-1];
    end
  end

  assign scl_s    = scl_sync[SYNC_STAGES-1];
  assign sda_s    = sda_sync[SYNC_STAGES-1];
  assign scl_rise = scl_s & ~scl_d;
  assign scl_fall = ~scl_s & scl_d;
  assign start    = scl_s & sda_d & ~sda_s;
  assign stop     = scl_s & ~sda_d & sda_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shift      <= '0;
      rx_data    <= '0;
      pull_low   <= 1'b0;
      rx_valid   <= 1'b0;
      tx_request <= 1'b0;
      busy       <= 1'b0;
      rw         <= 1'b0;
      gcall      <= 1'b0;
    end else begin
      state      <= state_nxt;
      bit_cnt    <= bit_cnt_nxt;
      shift      <= shift_nxt;
      rx_data    <= rx_data_nxt;
      pull_low   <= pull_low_nxt;
      rx_valid   <= rx_valid_nxt;
      tx_request <= tx_request_nxt;
      busy       <= busy_nxt;
      rw         <= rw_nxt;
      gcall      <= gcall_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    bit_cnt_nxt    = bit_cnt;
    shift_nxt      = shift;
    rx_data_nxt    = rx_data;
    pull_low_nxt   = pull_low;
    rx_valid_nxt   = 1'b0;
    tx_request_nxt = 1'b0;
    busy_nxt       = busy;
    rw_nxt         = rw;
    gcall_nxt      = gcall;
    if (start) begin
      state_nxt    = ADDR;
      bit_cnt_nxt  = '0;
      pull_low_nxt = 1'b0;
    end else if (stop) begin
      state_nxt    = IDLE;
      bit_cnt_nxt  = '0;
      pull_low_nxt = 1'b0;
      busy_nxt     = 1'b0;
      gcall_nxt    = 1'b0;
    end else begin
      unique case (state)
        ADDR: begin
          if (scl_rise && bit_cnt < CNT_W'(8)) begin
            shift_nxt   = {shift[6:0], sda_s};
            bit_cnt_nxt = bit_cnt + CNT_W'(1);
          end else if (scl_fall && bit_cnt == CNT_W'(8)) begin
            bit_cnt_nxt = '0;
            if (shift[7:1] == ADDRESS) begin
              state_nxt      = ADDR_ACK;
              pull_low_nxt   = 1'b1;
              rw_nxt         = shift[0];
              busy_nxt       = 1'b1;
              gcall_nxt      = 1'b0;
              tx_request_nxt = shift[0];
            end else if (GC_EN && shift == 8'h00) begin
              state_nxt    = ADDR_ACK;
              pull_low_nxt = 1'b1;
              rw_nxt       = 1'b0;
              busy_nxt     = 1'b1;
              gcall_nxt    = 1'b1;
            end else begin
              state_nxt    = WAIT_STOP;
              pull_low_nxt = 1'b0;
              busy_nxt     = 1'b0;
              gcall_nxt    = 1'b0;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            if (rw) begin
              state_nxt    = RD_DATA;
              shift_nxt    = bus.tx_data;
              pull_low_nxt = ~bus.tx_data[7];
              bit_cnt_nxt  = CNT_W'(1);
            end else begin
              state_nxt    = WR_DATA;
              pull_low_nxt = 1'b0;
              bit_cnt_nxt  = '0;
            end
          end
        end
        WR_DATA: begin
          if (scl_rise && bit_cnt < CNT_W'(8)) begin
            shift_nxt   = {shift[6:0], sda_s};
            bit_cnt_nxt = bit_cnt + CNT_W'(1);
            if (bit_cnt == CNT_W'(7)) begin
              rx_data_nxt  = {shift[6:0], sda_s};
              rx_valid_nxt = 1'b1;
            end
          end else if (scl_fall && bit_cnt == CNT_W'(8)) begin
            state_nxt    = WR_ACK;
            pull_low_nxt = 1'b1;
            bit_cnt_nxt  = '0;
          end
        end
        WR_ACK: begin
          if (scl_fall) begin
            state_nxt    = WR_DATA;
            pull_low_nxt = 1'b0;
          end
        end
        // bit_cnt counts bits already placed on SDA; the 9th fall hands SDA back to the master.
        RD_DATA: begin
          if (scl_fall) begin
            if (bit_cnt == CNT_W'(8)) begin
              state_nxt    = RD_ACK;
              pull_low_nxt = 1'b0;
              bit_cnt_nxt  = '0;
            end else begin
              shift_nxt    = {shift[6:0], 1'b0};
              pull_low_nxt = ~shift[6];
              bit_cnt_nxt  = bit_cnt + CNT_W'(1);
            end
          end
        end
        // bit_cnt==1 here records that the master acknowledged and wants another byte.
        RD_ACK: begin
          if (scl_rise) begin
            if (!sda_s) begin
              tx_request_nxt = 1'b1;
              bit_cnt_nxt    = CNT_W'(1);
            end else begin
              state_nxt = WAIT_STOP;
              busy_nxt  = 1'b0;
            end
          end else if (scl_fall && bit_cnt == CNT_W'(1)) begin
            state_nxt    = RD_DATA;
            shift_nxt    = bus.tx_data;
            pull_low_nxt = ~bus.tx_data[7];
            bit_cnt_nxt  = CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.sda_pull_low = pull_low;
  assign bus.rx_data      = rx_data;
  assign bus.rx_valid     = rx_valid;
  assign bus.tx_request   = tx_request;
  assign bus.busy         = busy;
  assign bus.rw           = rw;
  assign bus.general_call = gcall;

endmodule
